// File: rtl/output_port_allocator.sv
// Output-port allocator for one router output: round-robin arbitration with a
// wormhole lock, plus credit-based flow control toward the downstream buffer.
module output_port_allocator #(
  parameter int CREDIT_DEPTH = 4,
  parameter int CW           = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    req,
  input  logic [4:0]    tail,
  input  logic          credit_in,
  output logic [4:0]    RoutingDirection,
  output logic          grant_valid,
  output logic          xfer,
  output logic [CW-1:0] credits,
  output logic          credit_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CW-1:0] FULL = CW'(CREDIT_DEPTH);

  state_t        r_state;
  state_t        w_next_state;
  logic [4:0]    r_dir;
  logic [2:0]    r_owner;
  logic [2:0]    r_ptr;
  logic [CW-1:0] r_credits;
  logic          r_err;

  logic          w_has_credit;
  logic          w_xfer;
  logic          w_release;
  logic          w_found;
  logic [2:0]    w_win;
  logic          w_grant;

  assign w_has_credit = (r_credits != '0);
  // r_dir is zero while idle, so the mask alone confines xfer to the owner.
  assign w_xfer       = ~rst & (r_state == BUSY) & (|(req & r_dir)) & w_has_credit;
  assign w_release    = w_xfer & (|(tail & r_dir));
  assign w_grant      = (r_state == IDLE) && (w_next_state == BUSY);

  // Round-robin search starting one past the last released owner.
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    for (int k = 1; k <= 5; k++) begin
      if (!w_found && req[(int'(r_ptr) + k) % 5]) begin
        w_found = 1'b1;
        w_win   = 3'((int'(r_ptr) + k) % 5);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_found && w_has_credit) w_next_state = BUSY;
      BUSY:    if (w_release) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir     <= 5'b00000;
      r_owner   <= 3'd0;
      r_ptr     <= 3'd4;
      r_credits <= FULL;
      r_err     <= 1'b0;
    end else begin
      if (w_grant) begin
        r_dir   <= 5'b00001 << w_win;
        r_owner <= w_win;
      end else if (w_release) begin
        r_dir <= 5'b00000;
        r_ptr <= r_owner;
      end
      // A returned credit with the counter already full is a protocol error.
      if (w_xfer && !credit_in) begin
        r_credits <= r_credits - CW'(1);
      end else if (credit_in && !w_xfer) begin
        if (r_credits == FULL) r_err     <= 1'b1;
        else                   r_credits <= r_credits + CW'(1);
      end
    end
  end

  assign RoutingDirection = r_dir;
  assign grant_valid      = (r_state == BUSY);
  assign xfer             = w_xfer;
  assign credits          = r_credits;
  assign credit_err       = r_err;

endmodule

// File: tb/tb_output_port_allocator.sv
// Bench for output_port_allocator: directed vector table, hand-written credit
// stall sequence, then random traffic compared against a behavioural model.
module tb_output_port_allocator;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    req;
  logic [4:0]    tail;
  logic          credit_in;
  logic [4:0]    RoutingDirection;
  logic          grant_valid;
  logic          xfer;
  logic [CW-1:0] credits;
  logic          credit_err;

  output_port_allocator #(.CREDIT_DEPTH(DEPTH), .CW(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .tail             (tail),
    .credit_in        (credit_in),
    .RoutingDirection (RoutingDirection),
    .grant_valid      (grant_valid),
    .xfer             (xfer),
    .credits          (credits),
    .credit_err       (credit_err)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Behavioural model: owner index (-1 = none), rotation pointer, credit count.
  int mOwner;
  int mPtr;
  int mCredits;
  bit mErr;

  typedef struct {
    bit            r;
    logic [4:0]    rq;
    logic [4:0]    tl;
    bit            ci;
    logic [4:0]    eRD;
    logic          eGV;
    logic          eX;
    logic [CW-1:0] eCr;
    logic          eErr;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [4:0] modelDir();
    return (mOwner < 0) ? 5'b00000 : 5'(1 << mOwner);
  endfunction

  function automatic logic modelXfer();
    return (!rst && mOwner >= 0 && req[mOwner] && mCredits > 0);
  endfunction

  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input logic [4:0] rq, input logic [4:0] tl, input bit ci);
    rst       = r;
    req       = rq;
    tail      = tl;
    credit_in = ci;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] eRD, input logic eGV,
                             input logic eX, input logic [CW-1:0] eCr, input logic eErr);
    compare({tag, ".dir"},    8'(RoutingDirection), 8'(eRD));
    compare({tag, ".gv"},     8'(grant_valid),      8'(eGV));
    compare({tag, ".xfer"},   8'(xfer),             8'(eX));
    compare({tag, ".credit"}, 8'(credits),          8'(eCr));
    compare({tag, ".err"},    8'(credit_err),       8'(eErr));
    compare({tag, ".onehot"}, 8'($countones(RoutingDirection) <= 1), 8'd1);
  endtask

  // Advance the model across the coming edge, then move to just after it.
  task automatic tick();
    bit x;
    int nxt;
    int idx;
    x = modelXfer();
    if (rst) begin
      mOwner = -1; mPtr = 4; mCredits = DEPTH; mErr = 1'b0;
    end else begin
      nxt = mOwner;
      if (mOwner < 0) begin
        if (req != 5'b0 && mCredits > 0) begin
          for (int k = 1; k <= 5; k++) begin
            idx = (mPtr + k) % 5;
            if (nxt < 0 && req[idx]) nxt = idx;
          end
        end
      end else if (x && tail[mOwner]) begin
        mPtr = mOwner;
        nxt  = -1;
      end
      if (x && !credit_in) mCredits--;
      else if (credit_in && !x) begin
        if (mCredits == DEPTH) mErr = 1'b1;
        else mCredits++;
      end
      mOwner = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stepCheck(input string tag, input bit r, input logic [4:0] rq, input logic [4:0] tl,
                           input bit ci, input logic [4:0] eRD, input logic eGV, input logic eX,
                           input logic [CW-1:0] eCr, input logic eErr);
    applyStimulus(r, rq, tl, ci);
    #3;
    checkOutput(tag, eRD, eGV, eX, eCr, eErr);
    tick();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd4, 1'b0};
    vecs[1]  = '{1'b0, 5'b10001, 5'b10001, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd4, 1'b0};
    vecs[2]  = '{1'b0, 5'b00000, 5'b00000, 1'b0, 5'b00001, 1'b1, 1'b0, 3'd4, 1'b0};
    vecs[3]  = '{1'b0, 5'b00001, 5'b00001, 1'b0, 5'b00001, 1'b1, 1'b1, 3'd4, 1'b0};
    vecs[4]  = '{1'b0, 5'b10001, 5'b10001, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd3, 1'b0};
    vecs[5]  = '{1'b0, 5'b10001, 5'b10000, 1'b0, 5'b10000, 1'b1, 1'b1, 3'd3, 1'b0};
    vecs[6]  = '{1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 3'd2, 1'b0};
    vecs[7]  = '{1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 3'd3, 1'b0};
    vecs[8]  = '{1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 3'd4, 1'b0};
    vecs[9]  = '{1'b0, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd4, 1'b1};
    vecs[10] = '{1'b0, 5'b01000, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd4, 1'b1};
    vecs[11] = '{1'b0, 5'b11111, 5'b00000, 1'b0, 5'b01000, 1'b1, 1'b1, 3'd4, 1'b1};
    vecs[12] = '{1'b0, 5'b11111, 5'b00000, 1'b0, 5'b01000, 1'b1, 1'b1, 3'd3, 1'b1};
    vecs[13] = '{1'b0, 5'b11111, 5'b01000, 1'b1, 5'b01000, 1'b1, 1'b1, 3'd2, 1'b1};
    vecs[14] = '{1'b0, 5'b11111, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd2, 1'b1};
    vecs[15] = '{1'b0, 5'b11111, 5'b10000, 1'b0, 5'b10000, 1'b1, 1'b1, 3'd2, 1'b1};
    vecs[16] = '{1'b0, 5'b00100, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd1, 1'b1};
    vecs[17] = '{1'b1, 5'b00100, 5'b00000, 1'b0, 5'b00100, 1'b1, 1'b0, 3'd1, 1'b1};
    vecs[18] = '{1'b0, 5'b11111, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd4, 1'b0};
    vecs[19] = '{1'b0, 5'b00001, 5'b00001, 1'b0, 5'b00001, 1'b1, 1'b1, 3'd4, 1'b0};

    applyStimulus(1'b1, 5'b00000, 5'b00000, 1'b0);
    mOwner = -1; mPtr = 4; mCredits = DEPTH; mErr = 1'b0;
    tick();

    $display("[TB] directed vector table");
    for (int i = 0; i < 20; i++) begin
      stepCheck($sformatf("vec%0d", i), vecs[i].r, vecs[i].rq, vecs[i].tl, vecs[i].ci,
                vecs[i].eRD, vecs[i].eGV, vecs[i].eX, vecs[i].eCr, vecs[i].eErr);
    end

    $display("[TB] credit exhaustion sequence");
    applyStimulus(1'b1, 5'b00000, 5'b00000, 1'b0);
    tick();
    stepCheck("cr.arb", 1'b0, 5'b00010, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++)
      stepCheck($sformatf("cr.flit%0d", i), 1'b0, 5'b00010, 5'b00000, 1'b0,
                5'b00010, 1'b1, 1'b1, 3'(4 - i), 1'b0);
    for (int i = 0; i < 2; i++)
      stepCheck($sformatf("cr.stall%0d", i), 1'b0, 5'b00010, 5'b00000, 1'b0,
                5'b00010, 1'b1, 1'b0, 3'd0, 1'b0);
    stepCheck("cr.ret1",  1'b0, 5'b00010, 5'b00000, 1'b1, 5'b00010, 1'b1, 1'b0, 3'd0, 1'b0);
    stepCheck("cr.flit4", 1'b0, 5'b00010, 5'b00000, 1'b0, 5'b00010, 1'b1, 1'b1, 3'd1, 1'b0);
    stepCheck("cr.ret2",  1'b0, 5'b00010, 5'b00000, 1'b1, 5'b00010, 1'b1, 1'b0, 3'd0, 1'b0);
    stepCheck("cr.tail",  1'b0, 5'b00010, 5'b00010, 1'b0, 5'b00010, 1'b1, 1'b1, 3'd1, 1'b0);
    for (int i = 0; i < 2; i++)
      stepCheck($sformatf("cr.nogrant%0d", i), 1'b0, 5'b11111, 5'b00000, 1'b0,
                5'b00000, 1'b0, 1'b0, 3'd0, 1'b0);
    stepCheck("cr.ret3",  1'b0, 5'b11111, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b0);
    stepCheck("cr.arb2",  1'b0, 5'b11111, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd1, 1'b0);
    stepCheck("cr.north", 1'b0, 5'b11111, 5'b00100, 1'b0, 5'b00100, 1'b1, 1'b1, 3'd1, 1'b0);

    $display("[TB] random traffic against model");
    for (int i = 0; i < 600; i++) begin
      logic [4:0] tl;
      for (int b = 0; b < 5; b++) tl[b] = ($urandom_range(0, 2) == 0);
      applyStimulus($urandom_range(0, 59) == 0, 5'($urandom), tl, $urandom_range(0, 2) == 0);
      #3;
      checkOutput("rand", modelDir(), (mOwner >= 0), modelXfer(), 3'(mCredits), mErr);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
